// File: rtl/gate_mac_if.sv
// Operand/result bundle between the gate MAC and its producer/consumer.
// The master drives the start/bias/operand side; the slave returns the handshake and result.
interface gate_mac_if;
    logic               start;
    logic signed [15:0] bias;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic               ab_valid;
    logic               ab_ready;
    logic               busy;
    logic signed [15:0] x;
    logic               x_valid;
    logic               x_sat;

    modport master (
        output start, bias, a, b, ab_valid,
        input  ab_ready, busy, x, x_valid, x_sat
    );

    modport slave (
        input  start, bias, a, b, ab_valid,
        output ab_ready, busy, x, x_valid, x_sat
    );
endinterface

// File: rtl/gate_mac.sv
// Serial Q8.8 multiply-accumulate for one LSTM gate pre-activation: bias + sum(a*b),
// saturated to 16 bits at the output and held until the next result.
//
// state | meaning
// IDLE  | waiting for start; bias sampled on start
// ACCUM | accepting operand pairs, one per handshake
// DONE  | all pairs summed; result registered on the next edge
module gate_mac #(
    parameter int N_INPUTS  = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_WIDTH = 40
) (
    input  logic      clk,
    input  logic      rst,
    gate_mac_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] X_MAX = ACC_WIDTH'(32767);
    localparam logic signed [ACC_WIDTH-1:0] X_MIN = ACC_WIDTH'(-32768);

    state_t state, state_nxt;
    logic   ready, accept;

    logic        [CNT_W-1:0]     count;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] bias_ext, prod_ext, r;
    logic signed [31:0]          prod;
    logic                        sat_hi, sat_lo;
    logic signed [15:0]          x_clamped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = ACCUM;
            end
            ACCUM: begin
                ready  = 1'b1;
                accept = bus.ab_valid;
                if (accept && count == LAST) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ab_ready = ready;

    // Full-precision product; the accumulator is sized so this sum never wraps.
    assign prod     = 32'(bus.a) * 32'(bus.b);
    assign prod_ext = ACC_WIDTH'(prod);
    assign bias_ext = ACC_WIDTH'(bus.bias);

    assign r         = acc >>> FRAC_BITS;
    assign sat_hi    = r > X_MAX;
    assign sat_lo    = r < X_MIN;
    assign x_clamped = sat_hi ? 16'sh7fff : (sat_lo ? 16'sh8000 : r[15:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            count       <= '0;
            bus.x       <= '0;
            bus.x_valid <= 1'b0;
            bus.x_sat   <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            bus.x_valid <= 1'b0;
            bus.busy    <= (state_nxt != IDLE);
            if (state == IDLE && bus.start) begin
                acc   <= bias_ext <<< FRAC_BITS;
                count <= '0;
            end else if (accept) begin
                acc   <= acc + prod_ext;
                count <= count + CNT_W'(1);
            end
            // x/x_sat only change here so the downstream ROM sees a stable address.
            if (state == DONE) begin
                bus.x       <= x_clamped;
                bus.x_sat   <= sat_hi | sat_lo;
                bus.x_valid <= 1'b1;
            end
        end
    end
endmodule

// File: doc/gate_mac.md
# gate_mac

Serial multiply-accumulate stage that computes one LSTM gate pre-activation, bias + Σ aᵢ·bᵢ, in Q8.8 fixed point. It sits directly upstream of the activation lookup and drives that block's `x`/`x_valid` inputs. It consumes one operand pair per cycle over a valid/ready handshake. It emits a saturated 16-bit result that is held stable until the next result.

## Interface
Parameters:
- `N_INPUTS`, 16, number of operand pairs per gate; legal range 1..256.
- `FRAC_BITS`, 8, fractional bits of operands, bias and result (Q8.8; 256 = 1.0).
- `ACC_WIDTH`, 40, signed accumulator width; must be ≥ 32 + ceil(log2(N_INPUTS+1)).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a new accumulation; sampled only in IDLE.
- `bias`  in  16 signed  gate bias, Q8.8; sampled with `start`.
- `a`  in  16 signed  operand (weight), Q8.8.
- `b`  in  16 signed  operand (input or hidden value), Q8.8.
- `ab_valid`  in  1  `a`/`b` carry a valid pair.
- `ab_ready`  out  1  block accepts a pair this cycle.
- `busy`  out  1  accumulation in progress.
- `x`  out  16 signed  saturated pre-activation, Q8.8; feeds the lookup's `x`.
- `x_valid`  out  1  one-cycle pulse; `x` is new this cycle.
- `x_sat`  out  1  qualifies `x_valid`: the result was clamped.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `ab_ready`=0, `busy`=0.
  - When `start`=1: acc ← sign_extend(`bias`) << FRAC_BITS, count ← 0, go to ACCUM.
- ACCUM:
  - `ab_ready`=1, `busy`=1.
  - A pair is accepted on an edge where `ab_valid` and `ab_ready` are both 1.
  - On acceptance: acc ← acc + (`a`·`b`), using the full 32-bit signed product; count ← count+1.
  - The edge that accepts pair number N_INPUTS moves the block to DONE.
  - With `ab_valid`=0, acc and count hold.
- DONE:
  - `ab_ready`=0, `busy`=1.
  - r = acc >>> FRAC_BITS (arithmetic shift, floor; no rounding).
  - On the next edge: `x` ← clamp(r, −32768, 32767), `x_sat` ← (r out of range), `x_valid` ← 1, go to IDLE.
- `x` and `x_sat` hold their values until the next DONE→IDLE transition. The downstream ROM has read latency, so `x` must stay stable.
- `x_valid` is 1 for exactly one cycle per accumulation.
- `start` in ACCUM or DONE is ignored; it is not queued.
- `start` and `ab_valid` together in IDLE: no pair is consumed, because `ab_ready`=0.
- N_INPUTS=1: one accepted pair moves the block directly to DONE.
- The accumulator never wraps within the legal parameter range. Saturation happens only at the output.
- Reset, including mid-accumulation, forces:
  - state=IDLE, acc=0, count=0.
  - `x`=0, `x_valid`=0, `x_sat`=0, `busy`=0, `ab_ready`=0.
  - Partial sums are discarded.

## Timing
- `start` is sampled at edge E0. `ab_ready` and `busy` go high after E0.
- With `ab_valid` held high, pairs are accepted at E1..E_N (N = N_INPUTS).
- After E_N, `ab_ready` falls.
- At E_N+1: `x`, `x_sat` and `x_valid` update, and `busy` falls in the same cycle `x_valid` rises.
- Minimum latency from the `start` edge to the `x_valid` edge is N_INPUTS+1 cycles.
- The earliest next `start` is sampled at E_N+2, so throughput is one gate per N_INPUTS+2 cycles.
- Each bubble on `ab_valid` adds exactly one cycle of latency.
- All outputs are registered except `ab_ready`, which decodes state directly.

## Test plan
- **Basic sum:** N=4, bias=0, a=256, b=256,512,−256,128 back-to-back -> `x`=640, `x_sat`=0. `x_valid` is a single pulse 5 cycles after the `start` edge.
- **Floor behaviour:** N=4, bias=256, four pairs a=−1, b=1 -> acc=65532, `x`=255 (not 256), `x_sat`=0.
- **Saturation:**
  - Four pairs a=32767, b=32767 -> `x`=32767, `x_sat`=1.
  - Four pairs a=−32768, b=32767 -> `x`=−32768, `x_sat`=1.
  - In both cases `x` holds until the next result.
- **Backpressure:** same stimulus as the basic sum, with `ab_valid` low for 3 cycles between pairs 2 and 3 -> `x`=640. `x_valid` comes 3 cycles later than in the basic sum, and no pair is double-counted.
- **Reset mid-operation:** assert `rst` after 2 pairs are accepted -> all outputs 0 immediately. A new `start` with bias=0 and four pairs a=256, b=256 -> `x`=1024, with no stale contribution.
- **Start while busy:** hold `start` high through ACCUM and DONE -> the first result is unchanged. A new accumulation begins only at the first IDLE cycle, and `bias` is re-sampled then.
